// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is split into STAGES chunks,
// one chunk resolved per stage, with valid/ready flow control and result flags.
module adder_pipe #(
  parameter int n      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [1:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] SUM,
  output logic         COUT,
  output logic         OVF,
  output logic         ZERO
);

  localparam int W = n / STAGES;
  localparam int L = STAGES - 1;

  logic              w_stall;
  logic              w_accept;
  logic [n-1:0]      w_b_eff;
  logic              w_cin_eff;
  logic [n-1:0]      w_a     [STAGES];
  logic [n-1:0]      w_b     [STAGES];
  logic [n-1:0]      w_sum   [STAGES];
  logic [W:0]        w_chunk [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_v_in;
  logic              w_ovf_n;
  logic              w_zero_n;

  logic [n-1:0]      r_a   [STAGES];
  logic [n-1:0]      r_b   [STAGES];
  logic [n-1:0]      r_sum [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;
  logic              r_zero;

  assign w_stall  = r_v[L] && !out_ready;
  assign w_accept = in_valid && !w_stall;
  assign w_b_eff  = op[0] ? ~B : B;

  always_comb begin
    case (op)
      2'b00:   w_cin_eff = 1'b0;
      2'b01:   w_cin_eff = 1'b1;
      2'b10:   w_cin_eff = cin;
      default: w_cin_eff = !cin;
    endcase
  end

  // Stage k sees either the new operation (k=0) or stage k-1's registers.
  always_comb begin
    w_a[0]    = A;
    w_b[0]    = w_b_eff;
    w_c_in[0] = w_cin_eff;
    w_v_in[0] = w_accept;
    w_sum[0]  = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k]    = r_a[k-1];
      w_b[k]    = r_b[k-1];
      w_c_in[k] = r_c[k-1];
      w_v_in[k] = r_v[k-1];
      w_sum[k]  = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_a[k][k*W +: W]} + {1'b0, w_b[k][k*W +: W]}
                 + {{W{1'b0}}, w_c_in[k]};
      w_sum[k][k*W +: W] = w_chunk[k][W-1:0];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign w_ovf_n  = w_chunk[L][W] ^ (w_sum[L][n-1] ^ w_a[L][n-1] ^ w_b[L][n-1]);
  assign w_zero_n = (w_sum[L] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (!w_stall) begin
      r_v <= w_v_in;
      for (int k = 0; k < STAGES; k++) begin
        if (w_v_in[k]) begin
          r_a[k]   <= w_a[k];
          r_b[k]   <= w_b[k];
          r_sum[k] <= w_sum[k];
          r_c[k]   <= w_chunk[k][W];
        end
      end
      if (w_v_in[L]) begin
        r_ovf  <= w_ovf_n;
        r_zero <= w_zero_n;
      end
    end
  end

  assign in_ready  = !w_stall;
  assign out_valid = r_v[L];
  assign SUM       = r_sum[L];
  assign COUT      = r_c[L];
  assign OVF       = r_ovf;
  assign ZERO      = r_zero;

endmodule
